seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-add multiplier with a start/done handshake, signed/unsigned mode per operation and optional early termination. It generalises the fixed 16-bit repeated-addition multiplier datapath/controller pair. It sits between a register-loading source and any consumer that samples a `2*W`-bit product on `done`.

## Interface
- `W`, default 16: operand width; product is `2*W` bits.
- `EARLY_TERM`, default 1: when 1, RUN ends once the remaining multiplier bits are zero; when 0, RUN always lasts `W` cycles.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `start`  input  1  request to begin; sampled only when the block is not in RUN.
- `signed_mode`  input  1  operands are two's complement when 1; sampled together with `start`.
- `a`  input  W  multiplicand; sampled with `start`.
- `b`  input  W  multiplier; sampled with `start`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; `product` is valid in that cycle.
- `product`  output  2W  result; holds its value until the next DONE.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, with `busy=0`, `done=0`, `product=0` and all internal registers at 0.
- IDLE: if `start=1`, latch `mcand=|a|` zero-extended to `2W`, `mplier=|b|` (W bits, unsigned), `neg=signed_mode & (a[W-1]^b[W-1])`, clear `acc` and the counter, then go to RUN. If `start=0`, stay in IDLE.
- Magnitude rule: `|x|` is the two's-complement negation of `x` when `signed_mode=1` and `x[W-1]=1`; otherwise it is `x`. For `-2^(W-1)` this gives `2^(W-1)`, which is correct when treated as unsigned W-bit.
- Each RUN cycle:
  - If `mplier[0]=1`, then `acc += mcand` (`2W`-bit, no overflow possible).
  - `mcand <<= 1`, `mplier >>= 1`, counter increments.
- RUN exits to DONE when the counter reaches `W`, or, if `EARLY_TERM=1`, when `mplier>>1 == 0` in the current cycle.
- On entry to DONE: `product = neg ? -acc_final : acc_final`, where `acc_final` includes the last cycle's add.
- DONE: `done=1` for one cycle.
  - If `start=1` in this cycle, a new operation is accepted exactly as from IDLE and the next state is RUN (back-to-back).
  - Otherwise the next state is IDLE.
- `start` while in RUN is ignored and is not queued.
- Operands may change freely after the accepting edge.

## Timing
- Let edge 0 be the edge at which `start` is accepted.
- RUN cycle count N:
  - With `EARLY_TERM=0`, N = `W`.
  - With `EARLY_TERM=1`, N = max(1, index of the highest set bit of `|b|` + 1). For `b=0`, N = 1.
- `busy` is high after edge 0 through edge N. `done` and the new `product` appear after edge N+1. Latency is N+1 cycles, maximum `W+1`.
- Back-to-back throughput: one result every N+1 cycles.
- `rst_n=0` at any edge, including mid-RUN or in DONE, takes effect at that edge. It overrides `start`, and no `done` pulse follows for the aborted operation.
- `signed_mode=0`: `a` and `b` are pure unsigned and `neg=0`.

## Structure
- Shared package `mul_pkg` holds:
  - the state encoding localparams (`S_IDLE=2'd0`, `S_RUN=2'd1`, `S_DONE=2'd2`);
  - the default `W`;
  - a `CNT_W = $clog2(W+1)` width function/constant.
- Natural split is a datapath `seq_mul_datapath` (holding `mcand`, `mplier`, `acc`, counter, sign logic and `product` register) plus a control FSM in `seq_multiplier`. The FSM drives load, step and finish strobes and receives `last` (the termination condition).
- Expected size: 150–250 lines of RTL.

## Test plan
- `W=16`, unsigned, `a=17`, `b=5` → `product=85`. `busy` is high for 3 cycles and `done` pulses once, 4 cycles after edge 0.
- Signed, `a=16'hFFFD` (−3), `b=7` → `product=32'hFFFF_FFEB`. Signed, `a=b=16'h8000` → `product=32'h4000_0000`, with N=16.
- Unsigned `a=16'hFFFF`, `b=16'hFFFF` → `32'hFFFE_0001` with `done` at cycle 17. Unsigned `a=1234`, `b=0` → `product=0` with `done` at cycle 2.
- `start` pulsed with new operands during RUN → ignored, and the first result is correct. `start` held high in the DONE cycle with `a=3`, `b=4` → accepted, and a second `done` arrives 4 cycles later with `product=12`.
- `rst_n=0` for one cycle in the middle of RUN of `200*300` → the next cycle shows IDLE with `busy=0`, `done=0` and `product=0`, and no `done` pulse occurs within 40 cycles. A following `6*7` completes with `product=42`.
- `EARLY_TERM=0`, `a=9`, `b=2` → `product=18`, with `done` exactly `W+1=17` cycles after edge 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter width helper.
// No ports; imported by seq_mul_datapath and seq_multiplier.
package mul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_W = 16;

  // Counter must be able to hold the value W itself.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Shift-add multiplier datapath: magnitude/sign capture, accumulate, shift, product register.
// Latency: one add/shift step per step_i cycle; product_o updates the edge after finish_i.
// Backpressure: none; strobes are driven by the controlling FSM.
// Ports: clk, rst_n (sync, active-low); load_i/step_i/finish_i strobes; signed_mode_i, a_i, b_i
//        operands; last_o = termination condition for the current step; product_o = held result.
module seq_mul_datapath
  import mul_pkg::*;
#(
  parameter int W          = DEFAULT_W,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           finish_i,
  input  logic           signed_mode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           last_o,
  output logic [2*W-1:0] product_o
);

  localparam int CNT_W = cnt_w(W);

  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [2*W-1:0]   product_q, product_d;

  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  // Magnitudes are treated as unsigned W-bit values, so -2^(W-1) maps to 2^(W-1) correctly.
  assign abs_a = (signed_mode_i && a_i[W-1]) ? (~a_i + W'(1)) : a_i;
  assign abs_b = (signed_mode_i && b_i[W-1]) ? (~b_i + W'(1)) : b_i;

  // Stop after the W-th step, or early once no set multiplier bits remain above bit 0.
  always_comb begin
    last_o = (cnt_q == CNT_W'(W - 1));
    if (EARLY_TERM != 0 && mplier_q[W-1:1] == '0) begin
      last_o = 1'b1;
    end
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (load_i) begin
      mcand_d  = {{W{1'b0}}, abs_a};
      mplier_d = abs_b;
      neg_d    = signed_mode_i & (a_i[W-1] ^ b_i[W-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end

    // Uses the pre-load acc/neg, so a back-to-back load in the same cycle is safe.
    if (finish_i) begin
      product_d = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned shift-add multiplier with start/done handshake.
// Latency: N+1 cycles from the accepting edge (N = RUN cycles, at most W).
// Backpressure: start is ignored while busy; back-to-back start accepted in the DONE state.
// Ports: clk, rst_n (sync, active-low); start, signed_mode, a, b sampled on acceptance;
//        busy high during RUN; done one-cycle pulse with product valid; product held.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int W          = DEFAULT_W,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  logic [1:0] state_q, state_d;
  logic       done_q, done_d;
  logic       load, step, finish, last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last ? S_DONE : S_RUN;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath strobes. The result is registered out of the DONE state,
  // so done and the new product become visible together one edge later.
  always_comb begin
    busy   = (state_q == S_RUN);
    step   = (state_q == S_RUN);
    finish = (state_q == S_DONE);
    load   = start && (state_q != S_RUN);
    done_d = finish;
    done   = done_q;
  end

  seq_mul_datapath #(
    .W          (W),
    .EARLY_TERM (EARLY_TERM)
  ) u_datapath (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .step_i        (step),
    .finish_i      (finish),
    .signed_mode_i (signed_mode),
    .a_i           (a),
    .b_i           (b),
    .last_o        (last),
    .product_o     (product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        signed_mode;
  logic [15:0] a, b;
  logic        busy, done, busy2, done2;
  logic [31:0] product, product2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.W(16), .EARLY_TERM(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  seq_multiplier #(.W(16), .EARLY_TERM(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy2), .done(done2), .product(product2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is edge 0. Returns at the negedge
  // where done is sampled (or after the cycle bound).
  task automatic run_op(input string tag, input logic sm, input logic [15:0] aa,
                        input logic [15:0] bb, input logic [31:0] exp_p,
                        input int exp_lat, input int exp_busy);
    int cyc;
    int bcnt;
    start = 1'b1; signed_mode = sm; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); signed_mode = ~sm;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
    chk({tag, "_product"}, 64'(product), 64'(exp_p));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc;
    int ndone;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_product", 64'(product), 64'(0));
    chk("reset_full_product", 64'(product2), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u17x5", 1'b0, 16'd17, 16'd5, 32'd85, 4, 3);
    run_op("s_m3x7", 1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 4, 3);
    run_op("s_5xm4", 1'b1, 16'd5, 16'hFFFC, 32'hFFFF_FFEC, 4, 3);
    run_op("s_8000sq", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 17, 16);
    run_op("u_ffffsq", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 16);
    run_op("u_1234x0", 1'b0, 16'd1234, 16'd0, 32'd0, 2, 1);

    // start pulsed mid-RUN must be ignored and not queued
    start = 1'b1; signed_mode = 1'b0; a = 16'd11; b = 16'd13;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'd100; b = 16'd100;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("ignore_latency", 64'(cyc), 64'(5));
    chk("ignore_product", 64'(product), 64'(143));
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("ignore_not_queued", 64'(ndone), 64'(0));

    // back-to-back: start held in the DONE state
    start = 1'b1; a = 16'd10; b = 16'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_in_done_state_busy", 64'(busy), 64'(0));
    start = 1'b1; a = 16'd3; b = 16'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_first_done", 64'(done), 64'(1));
    chk("b2b_first_product", 64'(product), 64'(60));
    chk("b2b_accepted_busy", 64'(busy), 64'(1));
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_second_latency", 64'(cyc), 64'(4));
    chk("b2b_second_product", 64'(product), 64'(12));
    @(negedge clk);

    // reset mid-RUN of 200*300 (N=9)
    start = 1'b1; a = 16'd200; b = 16'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    chk("rst_mid_product", 64'(product), 64'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'(0));
    run_op("after_rst_6x7", 1'b0, 16'd6, 16'd7, 32'd42, 4, 3);

    // full-length instance: always W RUN cycles
    start2 = 1'b1; signed_mode = 1'b0; a = 16'd9; b = 16'd2;
    @(negedge clk);
    start2 = 1'b0; a = 16'hAAAA; b = 16'h5555;
    cyc = 0;
    while (!done2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("full_latency", 64'(cyc), 64'(17));
    chk("full_product", 64'(product2), 64'(18));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
